// File: rtl/gbp_instr_issue_if.sv
// Producer/processor-side bundle for the instruction issue stage.
// master = producer/testbench side, slave = issue stage.
interface gbp_instr_issue_if #(
    parameter int OPW  = 8,
    parameter int LW   = 4,
    parameter int CNTW = 16
);
    logic [OPW-1:0]  in_opcode;
    logic            in_valid;
    logic            in_ready;
    logic            hold;
    logic            flush;
    logic [OPW-1:0]  instruction;
    logic            valid;
    logic [LW-1:0]   level;
    logic [CNTW-1:0] issued_count;

    modport master (
        output in_opcode, in_valid, hold, flush,
        input  in_ready, instruction, valid, level, issued_count
    );

    modport slave (
        input  in_opcode, in_valid, hold, flush,
        output in_ready, instruction, valid, level, issued_count
    );
endinterface

// File: rtl/gbp_instr_issue.sv
// Opcode FIFO plus issue pacer: emits one-cycle valid pulses spaced at least
// GAP cycles apart, with hold (pause) and synchronous flush.
module gbp_instr_issue #(
    parameter int DEPTH = 8,
    parameter int OPW   = 8,
    parameter int GAP   = 1,
    parameter int CNTW  = 16
) (
    input logic               clock,
    input logic               reset,
    gbp_instr_issue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int GW = (GAP > 2) ? $clog2(GAP - 1) : 1;
    localparam logic [GW-1:0] GAP_RELOAD = (GAP > 2) ? GW'(GAP - 2) : '0;

    typedef enum logic {ST_IDLE, ST_GAP} state_t;

    state_t          state_q, state_d;
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [OPW-1:0]  instruction_q, instruction_d;
    logic            valid_q, valid_d;
    logic [CNTW-1:0] issued_count_q, issued_count_d;
    logic [OPW-1:0]  mem_q [DEPTH];

    logic [AW:0] occupancy;
    logic        full, empty, push;

    assign occupancy = wr_ptr_q - rd_ptr_q;
    assign full      = (occupancy == (AW+1)'(DEPTH));
    assign empty     = (wr_ptr_q == rd_ptr_q);
    // A push offered alongside flush is discarded with the rest of the FIFO.
    assign push      = bus.in_valid & ~full & ~bus.flush;

    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        gap_cnt_d      = gap_cnt_q;
        instruction_d  = instruction_q;
        valid_d        = 1'b0;
        issued_count_d = issued_count_q;

        if (bus.flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            gap_cnt_d = '0;
            state_d   = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!empty && !bus.hold) begin
                        instruction_d  = mem_q[rd_ptr_q[AW-1:0]];
                        valid_d        = 1'b1;
                        rd_ptr_d       = rd_ptr_q + (AW+1)'(1);
                        issued_count_d = issued_count_q + CNTW'(1);
                        if (GAP > 1) begin
                            gap_cnt_d = GAP_RELOAD;
                            state_d   = ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    // The gap countdown ignores hold so pacing is not stretched.
                    if (gap_cnt_q == '0) state_d = ST_IDLE;
                    else                 gap_cnt_d = gap_cnt_q - GW'(1);
                end
                default: state_d = ST_IDLE;
            endcase
            if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            gap_cnt_q      <= '0;
            instruction_q  <= '0;
            valid_q        <= 1'b0;
            issued_count_q <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            gap_cnt_q      <= gap_cnt_d;
            instruction_q  <= instruction_d;
            valid_q        <= valid_d;
            issued_count_q <= issued_count_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.in_opcode;
    end

    assign bus.in_ready     = ~full;
    assign bus.instruction  = instruction_q;
    assign bus.valid        = valid_q;
    assign bus.level        = LW'(occupancy);
    assign bus.issued_count = issued_count_q;
endmodule
